// File: rtl/mem_addr_arb_pkg.sv
// Shared types and helpers for the memory address arbiter.
package mem_addr_arb_pkg;

    localparam int MAX_SRC = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_pick.sv
// Combinational requester search: first set bit of req starting at 'start', wrapping.
module arb_pick
    import mem_addr_arb_pkg::*;
#(
    parameter int NUM_SRC = 2,
    parameter int SEL_W   = sel_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SEL_W-1:0]   start,
    output logic [SEL_W-1:0]   winner,
    output logic               any_req
);

    localparam int unsigned N = NUM_SRC;

    logic [NUM_SRC-1:0] w_rot;
    int unsigned        w_off;
    int unsigned        w_sum;
    logic               w_found;

    // Rotate right by start so bit 0 of w_rot is the first candidate.
    assign w_rot = NUM_SRC'({req, req} >> start);

    always_comb begin
        w_off   = 0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!w_found && w_rot[i]) begin
                w_off   = i;
                w_found = 1'b1;
            end
        end
        w_sum = 32'(start) + w_off;
        if (w_sum >= N) begin
            w_sum = w_sum - N;
        end
        winner  = SEL_W'(w_sum);
        any_req = |req;
    end

endmodule

// File: rtl/mem_addr_arbiter.sv
// Registered NUM_SRC-way address arbiter for the CPU memory port with optional timeout.
// Define MEM_ADDR_ARB_RR_EN for round-robin arbitration; fixed lowest-index priority otherwise.
module mem_addr_arbiter
    import mem_addr_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_SRC    = 2,
    parameter int TIMEOUT    = 0,
    localparam int SEL_W     = sel_width(NUM_SRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            req,
    input  logic [NUM_SRC*ADDR_WIDTH-1:0] addr_in,
    input  logic                          mem_ready,
    output logic [NUM_SRC-1:0]            gnt,
    output logic [SEL_W-1:0]              mem_sel,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic                          mem_valid,
    output logic [NUM_SRC-1:0]            done,
    output logic                          err
);

    localparam int unsigned N     = NUM_SRC;
    localparam int unsigned AW    = ADDR_WIDTH;
    localparam int          CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t                  r_state, w_state_next;
    logic [NUM_SRC-1:0]      r_gnt, w_gnt_next;
    logic [SEL_W-1:0]        r_sel, w_sel_next;
    logic [ADDR_WIDTH-1:0]   r_addr, w_addr_next;
    logic                    r_valid, w_valid_next;
    logic [NUM_SRC-1:0]      r_done, w_done_next;
    logic                    r_err, w_err_next;
    logic [CNT_W-1:0]        r_cnt, w_cnt_next;

    logic [SEL_W-1:0]        w_start;
    logic [SEL_W-1:0]        w_win;
    logic                    w_any;

`ifdef MEM_ADDR_ARB_RR_EN
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] w_ptr_next;

    assign w_start    = r_ptr;
    assign w_ptr_next = (32'(w_win) + 32'd1 >= N) ? '0 : w_win + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (r_state == IDLE && w_any) begin
            r_ptr <= w_ptr_next;
        end
    end
`else
    assign w_start = '0;
`endif

    arb_pick #(
        .NUM_SRC (NUM_SRC),
        .SEL_W   (SEL_W)
    ) u_pick (
        .req     (req),
        .start   (w_start),
        .winner  (w_win),
        .any_req (w_any)
    );

    always_comb begin
        w_state_next = r_state;
        w_gnt_next   = r_gnt;
        w_sel_next   = r_sel;
        w_addr_next  = r_addr;
        w_valid_next = r_valid;
        w_cnt_next   = r_cnt;
        w_done_next  = '0;
        w_err_next   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_state_next = BUSY;
                    w_gnt_next   = NUM_SRC'(1) << w_win;
                    w_sel_next   = w_win;
                    w_addr_next  = ADDR_WIDTH'(addr_in >> (32'(w_win) * AW));
                    w_valid_next = 1'b1;
                    w_cnt_next   = '0;
                end
            end
            BUSY: begin
                // A ready in the final timeout cycle still completes normally.
                if (mem_ready) begin
                    w_done_next  = r_gnt;
                    w_gnt_next   = '0;
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end else if (TIMEOUT > 0 && r_cnt == CNT_LAST) begin
                    w_err_next   = 1'b1;
                    w_gnt_next   = '0;
                    w_valid_next = 1'b0;
                    w_state_next = IDLE;
                end else if (TIMEOUT > 0) begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_sel   <= '0;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_done  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_gnt   <= w_gnt_next;
            r_sel   <= w_sel_next;
            r_addr  <= w_addr_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign gnt       = r_gnt;
    assign mem_sel   = r_sel;
    assign mem_addr  = r_addr;
    assign mem_valid = r_valid;
    assign done      = r_done;
    assign err       = r_err;

endmodule
